// File: rtl/if_stage_fetch.sv
// IF stage and IF/ID pipeline register of the 5-stage RISC-V pipeline.
// Owns the PC, drives the instruction-memory address, and latches {pc, inst}
// into IF/ID. It also detects load-use hazards against ID/EX, applies
// EX-stage redirects, asks for an ID/EX bubble, and counts stall and flush
// events with saturating counters.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_inst,
    output logic             ifid_valid,
    output logic             load_use_stall,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Opcodes that affect register-operand usage
    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_R     = 7'b0110011,
        OP_S     = 7'b0100011,
        OP_B     = 7'b1100011
    } opcode_e;

    // Step taken on the coming edge, highest priority first
    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_STALL,
        ACT_ADVANCE
    } action_e;

    logic [31:0]      pc_q,         pc_d;
    logic [31:0]      ifid_pc_q,    ifid_pc_d;
    logic [31:0]      ifid_inst_q,  ifid_inst_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;
    action_e          action;

    // Decode the IF/ID instruction's source-register usage
    always_comb begin
        opcode   = ifid_inst_q[6:0];
        rs1      = ifid_inst_q[19:15];
        rs2      = ifid_inst_q[24:20];
        uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    end

    // Load-use hazard detection and the resulting per-cycle action
    always_comb begin
        hazard = idex_memread && (idex_rd != 5'd0) && ifid_valid_q &&
                 ((uses_rs1 && (rs1 == idex_rd)) || (uses_rs2 && (rs2 == idex_rd)));
        if (ex_redirect) begin
            action = ACT_REDIRECT;
        end else if (hazard) begin
            action = ACT_STALL;
        end else begin
            action = ACT_ADVANCE;
        end
    end

    // Next-state for PC, IF/ID and counters; redirect masks any concurrent hazard
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        unique case (action)
            ACT_REDIRECT: begin
                pc_d         = ex_target & 32'hFFFF_FFFC;
                ifid_pc_d    = '0;
                ifid_inst_d  = NOP_INST;
                ifid_valid_d = 1'b0;
                if (flush_cnt_q != '1) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            ACT_STALL: begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                pc_d         = pc_q + 32'd4;
                ifid_pc_d    = pc_q;
                ifid_inst_d  = imem_rdata;
                ifid_valid_d = 1'b1;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_inst      = ifid_inst_q;
    assign ifid_valid     = ifid_valid_q;
    assign load_use_stall = hazard;
    assign idex_flush     = ex_redirect | hazard;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch stage.
module tb_if_stage_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD_X5_X3_X4 = 32'h0041_82B3;
    localparam logic [31:0] LUI_X3_1     = 32'h0000_11B7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = '0;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_rd = '0;

    logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_inst;
    logic        ifid_valid, load_use_stall, idex_flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] imem_addr_s, imem_rdata_s, ifid_pc_s, ifid_inst_s;
    logic        ifid_valid_s, load_use_stall_s, idex_flush_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc, m_ifid_pc, m_inst;
    logic        m_valid;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    assign imem_rdata   = mem[imem_addr[7:2]];
    assign imem_rdata_s = mem[imem_addr_s[7:2]];

    if_stage_fetch dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
        .load_use_stall(load_use_stall), .idex_flush(idex_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_stage_fetch #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_pc(ifid_pc_s), .ifid_inst(ifid_inst_s), .ifid_valid(ifid_valid_s),
        .load_use_stall(load_use_stall_s), .idex_flush(idex_flush_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // Expected hazard from the instruction-format rules
    function automatic logic model_hazard();
        logic [6:0] op;
        logic       r1, r2;
        op = m_inst[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return idex_memread && (idex_rd != 0) && m_valid &&
               ((r1 && m_inst[19:15] == idex_rd) || (r2 && m_inst[24:20] == idex_rd));
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step();
        if (ex_redirect) begin
            m_pc = {ex_target[31:2], 2'b00};
            m_ifid_pc = 32'h0; m_inst = NOP; m_valid = 1'b0;
            m_flush++;
        end else if (model_hazard()) begin
            m_stall++;
        end else begin
            m_ifid_pc = m_pc; m_inst = mem[m_pc[7:2]]; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: model follows the DUT edge; returns at the following negedge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [31:0] t, input logic mr, input logic [4:0] rd);
        ex_redirect = r; ex_target = t; idex_memread = mr; idex_rd = rd;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        model_reset();
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0 || ifid_pc !== 32'h0 || ifid_inst !== NOP || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state addr=%h pc=%h inst=%h valid=%b want 0/0/%h/0",
                     imem_addr, ifid_pc, ifid_inst, ifid_valid, NOP);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 32'(i * 4)) begin
                errors++;
                $display("FAIL fetch_seq[%0d] imem_addr=%h want %h", i, imem_addr, 32'(i * 4));
            end
            checks++;
            if (ifid_valid !== (i > 0) || (i > 0 && (ifid_pc !== 32'((i - 1) * 4) ||
                                                      ifid_inst !== mem[i - 1]))) begin
                errors++;
                $display("FAIL ifid_lag[%0d] pc=%h inst=%h valid=%b", i, ifid_pc, ifid_inst, ifid_valid);
            end
            cycle();
        end
    endtask

    task automatic test_load_use();
        mem[16] = ADD_X5_X3_X4;
        drive(1'b1, 32'h40, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        checks++;
        if (ifid_inst !== ADD_X5_X3_X4 || imem_addr !== 32'h44) begin
            errors++;
            $display("FAIL lu_setup inst=%h addr=%h want %h/00000044", ifid_inst, imem_addr, ADD_X5_X3_X4);
        end
        drive(1'b0, 32'h0, 1'b1, 5'd3);
        checks++;
        if (load_use_stall !== 1'b1 || idex_flush !== 1'b1) begin
            errors++;
            $display("FAIL lu_detect stall=%b flush=%b want 1/1", load_use_stall, idex_flush);
        end
        cycle();
        checks++;
        if (imem_addr !== 32'h44 || ifid_inst !== ADD_X5_X3_X4 || ifid_pc !== 32'h40 ||
            stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_hold addr=%h inst=%h pc=%h stall_cnt=%0d want 44/%h/40/1",
                     imem_addr, ifid_inst, ifid_pc, stall_cnt, ADD_X5_X3_X4);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        checks++;
        if (imem_addr !== 32'h48 || ifid_pc !== 32'h44) begin
            errors++;
            $display("FAIL lu_resume addr=%h ifid_pc=%h want 48/44", imem_addr, ifid_pc);
        end
    endtask

    task automatic test_no_false_hazard();
        mem[32] = LUI_X3_1;
        drive(1'b1, 32'h80, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b1, 5'd3);
        checks++;
        if (load_use_stall !== 1'b0 || idex_flush !== 1'b0 || ifid_inst !== LUI_X3_1) begin
            errors++;
            $display("FAIL nofalse_lui stall=%b flush=%b inst=%h want 0/0/%h",
                     load_use_stall, idex_flush, ifid_inst, LUI_X3_1);
        end
        drive(1'b1, 32'h40, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b1, 5'd0);
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL nofalse_x0 stall=%b want 0", load_use_stall);
        end
        drive(1'b0, 32'h0, 1'b1, 5'd4);
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_rs2 stall=%b want 1", load_use_stall);
        end
    endtask

    // Entered with add x5,x3,x4 in IF/ID
    task automatic test_redirect();
        int s0;
        s0 = m_stall;
        drive(1'b1, 32'h0000_0103, 1'b1, 5'd3);
        checks++;
        if (idex_flush !== 1'b1) begin
            errors++;
            $display("FAIL redir_flush idex_flush=%b want 1", idex_flush);
        end
        cycle();
        checks++;
        if (imem_addr !== 32'h100 || ifid_inst !== NOP || ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin
            errors++;
            $display("FAIL redir_state addr=%h inst=%h valid=%b pc=%h want 100/13/0/0",
                     imem_addr, ifid_inst, ifid_valid, ifid_pc);
        end
        checks++;
        if (flush_cnt !== 16'(m_flush) || stall_cnt !== 16'(s0)) begin
            errors++;
            $display("FAIL redir_counts flush=%0d stall=%0d want %0d/%0d", flush_cnt, stall_cnt, m_flush, s0);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        checks++;
        if (ifid_pc !== 32'h100 || ifid_inst !== mem[0] || ifid_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_latency pc=%h inst=%h valid=%b want 100/%h/1", ifid_pc, ifid_inst, ifid_valid, mem[0]);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        checks++;
        if (imem_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_inst !== mem[63]) begin
            errors++;
            $display("FAIL wrap addr=%h ifid_pc=%h inst=%h want 0/fffffffc/%h", imem_addr, ifid_pc, ifid_inst, mem[63]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem[16] = ADD_X5_X3_X4;
        drive(1'b1, 32'h40, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 5'd0);
        cycle();
        drive(1'b0, 32'h0, 1'b1, 5'd3);
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_saturate narrow=%0d wide=%0d want 3/5", stall_cnt_s, stall_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40, 1'b0, 5'd0);
            cycle();
        end
        checks++;
        if (flush_cnt_s !== 2'd3 || flush_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_saturate narrow=%0d wide=%0d want 3/5", flush_cnt_s, flush_cnt);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic test_async_reset();
        cycle();
        cycle();
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (imem_addr !== 32'h0 || ifid_pc !== 32'h0 || ifid_inst !== NOP || ifid_valid !== 1'b0 ||
            stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL async_reset addr=%h pc=%h inst=%h valid=%b stall=%0d flush=%0d",
                     imem_addr, ifid_pc, ifid_inst, ifid_valid, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        cycle();
        checks++;
        if (imem_addr !== 32'h4 || ifid_pc !== 32'h0 || ifid_inst !== mem[0]) begin
            errors++;
            $display("FAIL post_reset_fetch addr=%h ifid_pc=%h inst=%h want 4/0/%h",
                     imem_addr, ifid_pc, ifid_inst, mem[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            tgt = $urandom;
            tgt[31:8] = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'h0;
            drive(($urandom_range(0, 9) == 0), tgt, ($urandom_range(0, 9) < 4),
                  5'($urandom_range(0, 3)));
            checks++;
            if (imem_addr !== m_pc || ifid_pc !== m_ifid_pc || ifid_inst !== m_inst ||
                ifid_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_state[%0d] addr=%h pc=%h inst=%h v=%b want %h/%h/%h/%b",
                         i, imem_addr, ifid_pc, ifid_inst, ifid_valid, m_pc, m_ifid_pc, m_inst, m_valid);
            end
            checks++;
            if (load_use_stall !== model_hazard() || idex_flush !== (ex_redirect | model_hazard())) begin
                errors++;
                $display("FAIL rand_hazard[%0d] stall=%b flush=%b want %b/%b", i, load_use_stall,
                         idex_flush, model_hazard(), ex_redirect | model_hazard());
            end
            checks++;
            if (stall_cnt !== 16'(sat(m_stall, 65535)) || flush_cnt !== 16'(sat(m_flush, 65535)) ||
                stall_cnt_s !== 2'(sat(m_stall, 3)) || flush_cnt_s !== 2'(sat(m_flush, 3))) begin
                errors++;
                $display("FAIL rand_counts[%0d] stall=%0d flush=%0d s=%0d f=%0d model %0d/%0d",
                         i, stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s, m_stall, m_flush);
            end
            cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = rand_inst();
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_redirect();
        test_wrap();
        test_saturation();
        test_async_reset();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
